// File: rtl/kernel3_gmem_c_m_axi_wdata_burst_if.sv
// rtl/kernel3_gmem_c_m_axi_wdata_burst_if.sv - burst request, data FIFO and AXI W bundle for the gmem_C write-data framer
interface kernel3_gmem_c_m_axi_wdata_burst_if #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
);
  logic                      req_valid;
  logic                      req_ready;
  logic [LEN_WIDTH-1:0]      req_len;
  logic                      din_empty_n;
  logic                      din_read;
  logic [DATA_WIDTH-1:0]     din;
  logic [DATA_WIDTH/8-1:0]   din_strb;
  logic                      m_wvalid;
  logic                      m_wready;
  logic [DATA_WIDTH-1:0]     m_wdata;
  logic [DATA_WIDTH/8-1:0]   m_wstrb;
  logic                      m_wlast;
  logic                      burst_done;

  // The framer is the AXI W master; the environment supplies requests, FIFO data and wready.
  modport master (
    input  req_valid, req_len, din_empty_n, din, din_strb, m_wready,
    output req_ready, din_read, m_wvalid, m_wdata, m_wstrb, m_wlast, burst_done
  );

  modport slave (
    output req_valid, req_len, din_empty_n, din, din_strb, m_wready,
    input  req_ready, din_read, m_wvalid, m_wdata, m_wstrb, m_wlast, burst_done
  );
endinterface

// File: rtl/kernel3_gmem_c_m_axi_wdata_burst.sv
// rtl/kernel3_gmem_c_m_axi_wdata_burst.sv - pops the write-data FIFO and frames AXI W bursts with registered outputs
module kernel3_gmem_c_m_axi_wdata_burst #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clk_en,
  kernel3_gmem_c_m_axi_wdata_burst_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   wvalid_q, wlast_q, done_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [STRB_WIDTH-1:0]  wstrb_q;
  logic                   req_ready, din_read, slot_free;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    din_read  = 1'b0;
    slot_free = ~wvalid_q | bus.m_wready;
    case (state_q)
      IDLE: begin
        req_ready = clk_en & reset;
        if (req_ready && bus.req_valid) begin
          cnt_d   = bus.req_len;
          state_d = BURST;
        end
      end
      BURST: begin
        // A new word may only be loaded when the output slot is empty or draining this cycle.
        din_read = clk_en & reset & bus.din_empty_n & slot_free;
        if (din_read) begin
          if (cnt_q == '0) state_d = IDLE;
          else             cnt_d   = cnt_q - LEN_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wvalid_q <= 1'b0;
      wlast_q  <= 1'b0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      done_q   <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (din_read) begin
        wdata_q  <= bus.din;
        wstrb_q  <= bus.din_strb;
        wvalid_q <= 1'b1;
        wlast_q  <= (cnt_q == '0);
      end else if (wvalid_q && bus.m_wready) begin
        wvalid_q <= 1'b0;
        wlast_q  <= 1'b0;
      end
      done_q <= wvalid_q & bus.m_wready & wlast_q;
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.din_read   = din_read;
  assign bus.m_wvalid   = wvalid_q;
  assign bus.m_wdata    = wdata_q;
  assign bus.m_wstrb    = wstrb_q;
  assign bus.m_wlast    = wlast_q;
  assign bus.burst_done = done_q;
endmodule

// File: tb/tb_kernel3_gmem_c_m_axi_wdata_burst.sv
// tb/tb_kernel3_gmem_c_m_axi_wdata_burst.sv - scoreboard bench for the gmem_C write-data burst framer
module tb_kernel3_gmem_c_m_axi_wdata_burst;
  typedef struct { logic [31:0] d; logic [3:0] s; } word_t;
  typedef struct { logic [31:0] d; logic [3:0] s; logic l; } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic clk_en;

  kernel3_gmem_c_m_axi_wdata_burst_if #(.DATA_WIDTH(32), .LEN_WIDTH(8)) bus ();

  kernel3_gmem_c_m_axi_wdata_burst #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  word_t fifo[$];
  word_t pending[$];
  beat_t exp_q[$];
  int    hs_cyc[$];
  int    passed = 0, total = 0;
  int    cyc = 0, pops = 0, lasts = 0, dones = 0;
  int    wr_mode = 0, gap = 0, ce_off = 0;
  bit    rnd_mode = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Environment driver: FIFO head, wready pattern, clock enable.
  initial begin
    bit gap_now;
    bus.m_wready = 1'b1;
    bus.din_empty_n = 1'b0;
    bus.din = '0;
    bus.din_strb = '0;
    clk_en = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      case (wr_mode)
        0:       bus.m_wready = 1'b1;
        1:       bus.m_wready = ~bus.m_wready;
        default: bus.m_wready = ($urandom_range(0, 3) != 0);
      endcase
      if (ce_off > 0) begin
        clk_en = 1'b0;
        ce_off--;
      end else begin
        clk_en = rnd_mode ? ($urandom_range(0, 7) != 0) : 1'b1;
      end
      gap_now = (gap > 0) || (rnd_mode && $urandom_range(0, 3) == 0);
      if (gap > 0) gap--;
      if (fifo.size() > 0 && !gap_now) begin
        bus.din_empty_n = 1'b1;
        bus.din = fifo[0].d;
        bus.din_strb = fifo[0].s;
      end else begin
        bus.din_empty_n = 1'b0;
        bus.din = $urandom;
        bus.din_strb = 4'($urandom);
      end
    end
  end

  // Monitor: samples mid-cycle and predicts what the next rising edge will commit.
  initial begin
    bit have_prev, p_ce, p_v, p_r, p_l, p_done, hs, exp_done;
    logic [31:0] p_d;
    logic [3:0]  p_s;
    beat_t e;
    have_prev = 0;
    exp_done = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset) begin
        check(!bus.req_ready && !bus.din_read, "reset_handshake_gated", {bus.req_ready, bus.din_read}, 0);
        check(!bus.m_wvalid && !bus.m_wlast && !bus.burst_done, "reset_outputs",
              {bus.m_wvalid, bus.m_wlast, bus.burst_done}, 0);
        have_prev = 0;
        exp_done = 0;
      end else begin
        if (have_prev && !p_ce)
          check(bus.m_wvalid == p_v && bus.m_wdata == p_d && bus.m_wstrb == p_s &&
                bus.m_wlast == p_l && bus.burst_done == p_done, "clk_en_frozen",
                {bus.m_wvalid, bus.m_wlast, bus.m_wdata}, {p_v, p_l, p_d});
        else if (have_prev && p_v && !p_r)
          check(bus.m_wvalid && bus.m_wdata == p_d && bus.m_wstrb == p_s && bus.m_wlast == p_l,
                "axi_hold", {bus.m_wvalid, bus.m_wlast, bus.m_wdata}, {1'b1, p_l, p_d});
        check(bus.burst_done == exp_done, "burst_done", bus.burst_done, exp_done);
        if (!clk_en)
          check(!bus.req_ready && !bus.din_read, "clk_en_gating", {bus.req_ready, bus.din_read}, 0);
        if (bus.din_read) begin
          check(bus.din_empty_n == 1'b1, "pop_when_empty", bus.din_empty_n, 1);
          if (fifo.size() > 0) fifo.delete(0);
          pops++;
        end
        hs = bus.m_wvalid && bus.m_wready && clk_en;
        if (hs) begin
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_beat", bus.m_wdata, 0);
          end else begin
            e = exp_q.pop_front();
            check(bus.m_wdata == e.d, "wdata", bus.m_wdata, e.d);
            check(bus.m_wstrb == e.s, "wstrb", bus.m_wstrb, e.s);
            check(bus.m_wlast == e.l, "wlast", bus.m_wlast, e.l);
          end
          hs_cyc.push_back(cyc);
          if (bus.m_wlast) lasts++;
        end
        if (bus.burst_done && p_ce) dones++;
        if (clk_en) exp_done = hs && bus.m_wlast;
        have_prev = 1;
        p_ce = clk_en;
        p_v = bus.m_wvalid;
        p_r = bus.m_wready;
        p_d = bus.m_wdata;
        p_s = bus.m_wstrb;
        p_l = bus.m_wlast;
        p_done = bus.burst_done;
      end
    end
  end

  // Reference model: the W stream is the FIFO word sequence cut into len+1 beat frames.
  task automatic claim(input int len);
    word_t w;
    beat_t b;
    while (pending.size() < len + 1) begin
      w.d = $urandom;
      w.s = 4'($urandom_range(1, 15));
      fifo.push_back(w);
      pending.push_back(w);
    end
    for (int i = 0; i <= len; i++) begin
      w = pending.pop_front();
      b.d = w.d;
      b.s = w.s;
      b.l = (i == len);
      exp_q.push_back(b);
    end
  endtask

  task automatic issue(input int len);
    bit ok = 0;
    claim(len);
    bus.req_valid = 1'b1;
    bus.req_len = 8'(len);
    for (int i = 0; i < 2000; i++) begin
      #1;
      if (bus.req_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check(ok, "req_accept_timeout", ok, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    check(exp_q.size() == 0, "drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : test
    int p0, d0, l0;
    bit pre;
    reset = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_len = '0;
    #500000;
  end

  initial begin
    int p0, d0, l0;
    bit pre;
    reset = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_len = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Four-beat burst at full rate.
    hs_cyc.delete(); p0 = pops; d0 = dones; l0 = lasts;
    issue(3);
    wait_drain();
    check(hs_cyc.size() == 4, "t1_beats", hs_cyc.size(), 4);
    if (hs_cyc.size() == 4) check(hs_cyc[3] - hs_cyc[0] == 3, "t1_consecutive", hs_cyc[3] - hs_cyc[0], 3);
    check(pops - p0 == 4, "t1_pops", pops - p0, 4);
    check(dones - d0 == 1, "t1_done", dones - d0, 1);
    check(lasts - l0 == 1, "t1_wlast", lasts - l0, 1);

    // Three single-beat bursts back-to-back.
    hs_cyc.delete(); d0 = dones; l0 = lasts;
    issue(0); issue(0); issue(0);
    wait_drain();
    check(hs_cyc.size() == 3, "t2_beats", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) begin
      check(hs_cyc[1] - hs_cyc[0] == 2, "t2_gap01", hs_cyc[1] - hs_cyc[0], 2);
      check(hs_cyc[2] - hs_cyc[1] == 2, "t2_gap12", hs_cyc[2] - hs_cyc[1], 2);
    end
    check(dones - d0 == 3, "t2_done", dones - d0, 3);
    check(lasts - l0 == 3, "t2_wlast", lasts - l0, 3);

    // Maximum length with wready toggling.
    hs_cyc.delete(); p0 = pops; l0 = lasts;
    wr_mode = 1;
    issue(255);
    wait_drain();
    wr_mode = 0;
    check(hs_cyc.size() == 256, "t3_beats", hs_cyc.size(), 256);
    check(pops - p0 == 256, "t3_pops", pops - p0, 256);
    check(lasts - l0 == 1, "t3_wlast", lasts - l0, 1);

    // FIFO runs dry after three pops.
    hs_cyc.delete(); p0 = pops; l0 = lasts;
    issue(7);
    for (int i = 0; i < 500 && pops - p0 < 3; i++) begin
      @(negedge clk);
      #2;
    end
    gap = 5;
    repeat (3) @(negedge clk);
    #2;
    check(bus.m_wvalid == 1'b0, "t4_gap_wvalid_low", bus.m_wvalid, 0);
    wait_drain();
    check(hs_cyc.size() == 8, "t4_beats", hs_cyc.size(), 8);
    check(lasts - l0 == 1, "t4_wlast", lasts - l0, 1);

    // Clock enable dropped mid-burst.
    hs_cyc.delete(); l0 = lasts;
    issue(15);
    for (int i = 0; i < 500 && hs_cyc.size() < 2; i++) begin
      @(negedge clk);
      #2;
    end
    ce_off = 4;
    repeat (2) @(negedge clk);
    #2;
    check(bus.m_wvalid == 1'b1, "t5_frozen_valid", bus.m_wvalid, 1);
    check(!bus.din_read && !bus.req_ready, "t5_gated", {bus.din_read, bus.req_ready}, 0);
    wait_drain();
    check(hs_cyc.size() == 16, "t5_beats", hs_cyc.size(), 16);
    check(lasts - l0 == 1, "t5_wlast", lasts - l0, 1);

    // Asynchronous reset in the middle of a 16-beat burst.
    hs_cyc.delete();
    issue(15);
    for (int i = 0; i < 500 && hs_cyc.size() < 5; i++) begin
      @(negedge clk);
      #2;
    end
    @(posedge clk);
    #1;
    pre = bus.m_wvalid;
    reset = 1'b0;
    #1;
    check(pre == 1'b1, "t6_valid_before_reset", pre, 1);
    check(!bus.m_wvalid && !bus.m_wlast, "t6_async_drop", {bus.m_wvalid, bus.m_wlast}, 0);
    exp_q.delete();
    pending = fifo;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    hs_cyc.delete(); p0 = pops;
    issue(1);
    wait_drain();
    check(hs_cyc.size() == 2, "t6_beats", hs_cyc.size(), 2);
    check(pops - p0 == 2, "t6_pops", pops - p0, 2);
    if (pending.size() > 0) begin
      issue(pending.size() - 1);
      wait_drain();
    end

    // Randomised traffic.
    rnd_mode = 1;
    wr_mode = 2;
    for (int k = 0; k < 20; k++) issue($urandom_range(0, 40));
    wait_drain();
    rnd_mode = 0;
    wr_mode = 0;
    repeat (4) @(negedge clk);

    check(fifo.size() == 0 && pending.size() == 0, "final_fifo_empty", fifo.size(), 0);
    check(exp_q.size() == 0, "final_scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end
endmodule
